// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-scanline sprite slot scheduler.
// Scans the object table during hblank and loads the first
// NUM_SLOTS sprites covering next_y into the renderer slots.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   line_start, next_y  scan trigger and line to be drawn next
//   wr_en, wr_idx,
//   wr_x, wr_y,
//   wr_active           object table write port
//   slot_x, slot_y,
//   slot_id, slot_valid packed per-slot outputs (slot 0 = top)
//   busy, done          scan in progress / commit pulse
//   overflow            last committed line had too many hits
//   overflow_count      saturating count of overflow lines
// Optional: define SPRITE_OVERFLOW_COUNT_EN to build the
// overflow line counter; otherwise overflow_count is 0.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 16,
    parameter int NUM_SLOTS   = 4,
    parameter int SPRITE_SIZE = 32,
    parameter int IDX_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [9:0]                 next_y,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [9:0]                 wr_x,
    input  logic [9:0]                 wr_y,
    input  logic                       wr_active,
    output logic [10*NUM_SLOTS-1:0]    slot_x,
    output logic [10*NUM_SLOTS-1:0]    slot_y,
    output logic [IDX_W*NUM_SLOTS-1:0] slot_id,
    output logic [NUM_SLOTS-1:0]       slot_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [7:0]                 overflow_count
);

    localparam int HC_W = $clog2(NUM_SLOTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [HC_W-1:0]  FULL     = HC_W'(NUM_SLOTS);
    localparam logic [10:0]      SIZE_11  = 11'(SPRITE_SIZE);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t state, state_nxt;

    logic [9:0]             tab_x [NUM_SPRITES];
    logic [9:0]             tab_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] tab_act;

    logic [9:0]                 ty;
    logic [IDX_W-1:0]           scan_idx;
    logic [HC_W-1:0]            hit_cnt;
    logic [10*NUM_SLOTS-1:0]    sh_x;
    logic [10*NUM_SLOTS-1:0]    sh_y;
    logic [IDX_W*NUM_SLOTS-1:0] sh_id;
    logic [NUM_SLOTS-1:0]       sh_valid;
    logic                       ovf_pend;

    logic [10:0] ty_w;
    logic [10:0] y_w;
    logic        hit;

    // 11-bit compare so y + SPRITE_SIZE cannot wrap past line 1023.
    assign ty_w = {1'b0, ty};
    assign y_w  = {1'b0, tab_y[scan_idx]};
    assign hit  = tab_act[scan_idx] && (ty_w >= y_w) &&
                  (ty_w < y_w + SIZE_11);

    assign busy = (state != IDLE);

    // A new line_start always restarts the scan, even mid-commit.
    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = SCAN;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                SCAN:    if (scan_idx == LAST_IDX) state_nxt = COMMIT;
                COMMIT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Scan reads the pre-write value; writes land at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tab_act <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
            end
        end else if (wr_en) begin
            tab_x[wr_idx]   <= wr_x;
            tab_y[wr_idx]   <= wr_y;
            tab_act[wr_idx] <= wr_active;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ty         <= '0;
            scan_idx   <= '0;
            hit_cnt    <= '0;
            sh_x       <= '0;
            sh_y       <= '0;
            sh_id      <= '0;
            sh_valid   <= '0;
            ovf_pend   <= 1'b0;
            slot_x     <= '0;
            slot_y     <= '0;
            slot_id    <= '0;
            slot_valid <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (line_start) begin
                ty       <= next_y;
                scan_idx <= '0;
                hit_cnt  <= '0;
                sh_x     <= '0;
                sh_y     <= '0;
                sh_id    <= '0;
                sh_valid <= '0;
                ovf_pend <= 1'b0;
            end else if (state == SCAN) begin
                scan_idx <= scan_idx + 1'b1;
                if (hit) begin
                    if (hit_cnt < FULL) begin
                        for (int k = 0; k < NUM_SLOTS; k++) begin
                            if (hit_cnt == HC_W'(k)) begin
                                sh_x[10*k +: 10]       <= tab_x[scan_idx];
                                sh_y[10*k +: 10]       <= tab_y[scan_idx];
                                sh_id[IDX_W*k +: IDX_W] <= scan_idx;
                                sh_valid[k]            <= 1'b1;
                            end
                        end
                        hit_cnt <= hit_cnt + 1'b1;
                    end else begin
                        ovf_pend <= 1'b1;
                    end
                end
            end else if (state == COMMIT) begin
                slot_x     <= sh_x;
                slot_y     <= sh_y;
                slot_id    <= sh_id;
                slot_valid <= sh_valid;
                overflow   <= ovf_pend;
                done       <= 1'b1;
            end
        end
    end

`ifdef SPRITE_OVERFLOW_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_count <= '0;
        end else if (state == COMMIT && !line_start && ovf_pend &&
                     overflow_count != 8'hFF) begin
            overflow_count <= overflow_count + 8'd1;
        end
    end
`else
    assign overflow_count = 8'd0;
`endif

endmodule
